// File: rtl/floo_pkg.sv
// Shared NoC definitions: routing algorithm selector and small helpers.
package floo_pkg;

  typedef enum logic [1:0] {
    IdTable       = 2'd0,
    XYRouting     = 2'd1,
    SourceRouting = 2'd2
  } route_algo_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_route_lookup.sv
// Combinational address/ID -> {id, route, err} resolution for one request.
// Address map rules are packed {idx, start_addr, end_addr}; a hit is start <= addr < end, last hit wins.
module floo_route_lookup import floo_pkg::*; #(
  parameter route_algo_e RouteAlgo     = IdTable,
  parameter bit          UseIdTable    = 1'b1,
  parameter int unsigned XYAddrOffsetX = 0,
  parameter int unsigned XYAddrOffsetY = 0,
  parameter int unsigned IdAddrOffset  = 0,
  parameter int unsigned NumAddrRules  = 1,
  parameter int unsigned NumRoutes     = 1,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned XWidth        = 2,
  parameter int unsigned RouteWidth    = 8,
  localparam int unsigned RuleWidth    = IdWidth + 2 * AddrWidth,
  localparam int unsigned YWidth       = IdWidth - XWidth
) (
  input  logic [AddrWidth-1:0]              addr_i,
  input  logic [IdWidth-1:0]                id_i,
  input  logic [NumAddrRules*RuleWidth-1:0] addr_map_i,
  input  logic [NumRoutes*RouteWidth-1:0]   route_table_i,
  output logic [IdWidth-1:0]                id_o,
  output logic [RouteWidth-1:0]             route_o,
  output logic                              err_o
);

  if (RouteAlgo != IdTable && RouteAlgo != XYRouting && RouteAlgo != SourceRouting) begin : gen_bad_algo
    $fatal(1, "floo_route_lookup: unsupported routing algorithm");
  end

  logic [RuleWidth-1:0] rule;
  logic [IdWidth-1:0]   dec_id;
  logic                 dec_miss;

  always_comb begin
    rule     = '0;
    dec_id   = '0;
    dec_miss = 1'b1;
    for (int unsigned r = 0; r < NumAddrRules; r++) begin
      rule = addr_map_i[r*RuleWidth +: RuleWidth];
      if (addr_i >= rule[2*AddrWidth-1:AddrWidth] && addr_i < rule[AddrWidth-1:0]) begin
        dec_id   = rule[RuleWidth-1:2*AddrWidth];
        dec_miss = 1'b0;
      end
    end
  end

  always_comb begin
    id_o    = '0;
    route_o = '0;
    err_o   = 1'b0;
    if (UseIdTable) begin
      id_o  = dec_id;
      err_o = dec_miss;
    end else if (RouteAlgo == XYRouting) begin
      id_o = {addr_i[XYAddrOffsetY +: YWidth], addr_i[XYAddrOffsetX +: XWidth]};
    end else if (RouteAlgo == IdTable) begin
      id_o = addr_i[IdAddrOffset +: IdWidth];
    end else begin
      id_o = id_i;
    end
    // Out-of-range route index leaves the route zeroed and flags an error.
    if (RouteAlgo == SourceRouting) begin
      if (32'(id_o) >= NumRoutes) begin
        err_o = 1'b1;
      end else begin
        route_o = route_table_i[32'(id_o)*RouteWidth +: RouteWidth];
      end
    end
  end

endmodule

// File: rtl/floo_route_comp_arb.sv
// Shared registered route computation: round-robin over requesters, one lookup, 1-cycle result register.
// Inputs are granted only when the result register is empty or being drained; ready_o is held low in reset.
module floo_route_comp_arb import floo_pkg::*; #(
  parameter int unsigned NumChannels   = 2,
  parameter route_algo_e RouteAlgo     = IdTable,
  parameter bit          UseIdTable    = 1'b1,
  parameter int unsigned XYAddrOffsetX = 0,
  parameter int unsigned XYAddrOffsetY = 0,
  parameter int unsigned IdAddrOffset  = 0,
  parameter int unsigned NumAddrRules  = 1,
  parameter int unsigned NumRoutes     = 1,
  parameter int unsigned ErrCntWidth   = 8,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned XWidth        = 2,
  parameter int unsigned RouteWidth    = 8,
  localparam int unsigned ChanWidth    = idx_width(NumChannels),
  localparam int unsigned RuleWidth    = IdWidth + 2 * AddrWidth
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumChannels-1:0]            valid_i,
  output logic [NumChannels-1:0]            ready_o,
  input  logic [NumChannels*AddrWidth-1:0]  addr_i,
  input  logic [NumChannels*IdWidth-1:0]    id_i,
  input  logic [NumAddrRules*RuleWidth-1:0] addr_map_i,
  input  logic [NumRoutes*RouteWidth-1:0]   route_table_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [ChanWidth-1:0]              chan_o,
  output logic [IdWidth-1:0]                id_o,
  output logic [RouteWidth-1:0]             route_o,
  output logic                              dec_err_o,
  output logic [ErrCntWidth-1:0]            err_cnt_o,
  input  logic                              err_clr_i
);

  logic                   valid_q, valid_d;
  logic [ChanWidth-1:0]   chan_q, chan_d, rr_q, rr_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic [RouteWidth-1:0]  route_q, route_d;
  logic                   err_q, err_d;
  logic [ErrCntWidth-1:0] cnt_q, cnt_d;

  logic                   acc, hs, gnt_vld;
  logic [ChanWidth-1:0]   gnt_idx, cand;
  logic [IdWidth-1:0]     lk_id;
  logic [RouteWidth-1:0]  lk_route;
  logic                   lk_err;

  assign acc = !valid_q || ready_i;
  assign hs  = acc && gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      cand = ChanWidth'((32'(rr_q) + i) % NumChannels);
      if (!gnt_vld && valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    ready_o = '0;
    if (hs && !rst_i) ready_o[gnt_idx] = 1'b1;
  end

  floo_route_lookup #(
    .RouteAlgo     (RouteAlgo),
    .UseIdTable    (UseIdTable),
    .XYAddrOffsetX (XYAddrOffsetX),
    .XYAddrOffsetY (XYAddrOffsetY),
    .IdAddrOffset  (IdAddrOffset),
    .NumAddrRules  (NumAddrRules),
    .NumRoutes     (NumRoutes),
    .AddrWidth     (AddrWidth),
    .IdWidth       (IdWidth),
    .XWidth        (XWidth),
    .RouteWidth    (RouteWidth)
  ) i_lookup (
    .addr_i        (addr_i[32'(gnt_idx)*AddrWidth +: AddrWidth]),
    .id_i          (id_i[32'(gnt_idx)*IdWidth +: IdWidth]),
    .addr_map_i    (addr_map_i),
    .route_table_i (route_table_i),
    .id_o          (lk_id),
    .route_o       (lk_route),
    .err_o         (lk_err)
  );

  always_comb begin
    valid_d = acc ? gnt_vld : valid_q;
    chan_d  = chan_q;
    id_d    = id_q;
    route_d = route_q;
    err_d   = err_q;
    rr_d    = rr_q;
    if (hs) begin
      chan_d  = gnt_idx;
      id_d    = lk_id;
      route_d = lk_route;
      err_d   = lk_err;
      rr_d    = (32'(gnt_idx) == NumChannels - 1) ? '0 : gnt_idx + 1'b1;
    end
    // Clear has priority over an increment in the same cycle.
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = '0;
    end else if (hs && lk_err && cnt_q != {ErrCntWidth{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      chan_q  <= '0;
      id_q    <= '0;
      route_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      chan_q  <= chan_d;
      id_q    <= id_d;
      route_q <= route_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign valid_o   = valid_q;
  assign chan_o    = chan_q;
  assign id_o      = id_q;
  assign route_o   = route_q;
  assign dec_err_o = err_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: tb/tb_floo_route_comp_arb.sv
// Bench: table-mode 3-channel instance with a cycle model + scoreboard, and a source-routing instance.
module tb_floo_route_comp_arb;
  import floo_pkg::*;

  localparam int AW = 16;
  localparam int IW = 4;
  localparam int RW = 8;
  localparam int RuleW = IW + 2 * AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: table mode, 3 channels, 2-bit error counter
  logic [2:0]         a_valid, a_ready;
  logic [3*AW-1:0]    a_addr;
  logic [3*IW-1:0]    a_idin;
  logic [2*RuleW-1:0] a_map;
  logic [RW-1:0]      a_rt;
  logic               a_vo, a_ri, a_err, a_clr;
  logic [1:0]         a_chan, a_cnt;
  logic [IW-1:0]      a_id;
  logic [RW-1:0]      a_route;

  // Instance B: source routing from id_i, 4 routes
  logic [1:0]         b_valid, b_ready;
  logic [2*AW-1:0]    b_addr;
  logic [2*IW-1:0]    b_idin;
  logic [RuleW-1:0]   b_map;
  logic [4*RW-1:0]    b_rt;
  logic               b_vo, b_ri, b_err, b_clr;
  logic [0:0]         b_chan;
  logic [IW-1:0]      b_id;
  logic [RW-1:0]      b_route;
  logic [7:0]         b_cnt;

  floo_route_comp_arb #(
    .NumChannels(3), .RouteAlgo(IdTable), .UseIdTable(1'b1), .NumAddrRules(2),
    .NumRoutes(1), .ErrCntWidth(2), .AddrWidth(AW), .IdWidth(IW), .XWidth(2), .RouteWidth(RW)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .ready_o(a_ready), .addr_i(a_addr),
    .id_i(a_idin), .addr_map_i(a_map), .route_table_i(a_rt), .valid_o(a_vo), .ready_i(a_ri),
    .chan_o(a_chan), .id_o(a_id), .route_o(a_route), .dec_err_o(a_err), .err_cnt_o(a_cnt),
    .err_clr_i(a_clr)
  );

  floo_route_comp_arb #(
    .NumChannels(2), .RouteAlgo(SourceRouting), .UseIdTable(1'b0), .NumAddrRules(1),
    .NumRoutes(4), .ErrCntWidth(8), .AddrWidth(AW), .IdWidth(IW), .XWidth(2), .RouteWidth(RW)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .ready_o(b_ready), .addr_i(b_addr),
    .id_i(b_idin), .addr_map_i(b_map), .route_table_i(b_rt), .valid_o(b_vo), .ready_i(b_ri),
    .chan_o(b_chan), .id_o(b_id), .route_o(b_route), .dec_err_o(b_err), .err_cnt_o(b_cnt),
    .err_clr_i(b_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Bench-side address map for instance A
  logic [IW-1:0] r_idx [2];
  logic [AW-1:0] r_lo  [2];
  logic [AW-1:0] r_hi  [2];

  task automatic apply_map();
    for (int r = 0; r < 2; r++) a_map[r*RuleW +: RuleW] = {r_idx[r], r_lo[r], r_hi[r]};
  endtask

  typedef struct packed {
    logic [1:0]    chan;
    logic [IW-1:0] id;
    logic          err;
  } exp_t;

  exp_t sb[$];
  bit   m_vld;
  int   m_rr;
  int   m_cnt;

  function automatic exp_t expect_a(input int ch);
    exp_t e;
    logic [AW-1:0] ad;
    ad = a_addr[ch*AW +: AW];
    e.chan = 2'(ch);
    e.id   = '0;
    e.err  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (ad >= r_lo[r] && ad < r_hi[r]) begin
        e.id  = r_idx[r];
        e.err = 1'b0;
      end
    end
    return e;
  endfunction

  // Called at a falling edge with inputs already driven; checks, then advances the model by one edge.
  task automatic a_cycle();
    int   g;
    logic acc;
    logic [2:0] exp_rdy;
    exp_t e;
    #1;
    acc = !m_vld || a_ri;
    g = -1;
    for (int i = 0; i < 3; i++) if (g < 0 && a_valid[(m_rr + i) % 3]) g = (m_rr + i) % 3;
    exp_rdy = '0;
    if (acc && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("a_ready_o", 32'(a_ready), 32'(exp_rdy));
    check_eq("a_valid_o", 32'(a_vo), 32'(m_vld));
    check_eq("a_err_cnt", 32'(a_cnt), 32'(m_cnt));
    check_eq("a_route_zero", 32'(a_route), 32'd0);
    if (m_vld) begin
      if (sb.size() == 0) begin
        check_eq("a_sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb[0];
        check_eq("a_chan", 32'(a_chan), 32'(e.chan));
        check_eq("a_id", 32'(a_id), 32'(e.id));
        check_eq("a_dec_err", 32'(a_err), 32'(e.err));
        if (a_ri) void'(sb.pop_front());
      end
    end
    if (acc && g >= 0) e = expect_a(g);
    if (a_clr) m_cnt = 0;
    else if (acc && g >= 0 && e.err && m_cnt < 3) m_cnt++;
    if (acc && g >= 0) begin
      sb.push_back(e);
      m_rr  = (g + 1) % 3;
      m_vld = 1'b1;
    end else if (acc) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic b_step(input int ch, input logic [IW-1:0] idv, input logic [RW-1:0] exp_route,
                        input logic exp_err);
    b_valid = '0;
    b_valid[ch] = 1'b1;
    b_idin[ch*IW +: IW] = idv;
    #1;
    check_eq("b_ready_o", 32'(b_ready), 32'(1 << ch));
    @(posedge clk);
    #1;
    check_eq("b_valid_o", 32'(b_vo), 32'd1);
    check_eq("b_chan", 32'(b_chan), 32'(ch));
    check_eq("b_id", 32'(b_id), 32'(idv));
    check_eq("b_route", 32'(b_route), 32'(exp_route));
    check_eq("b_dec_err", 32'(b_err), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    r_idx[0] = 4'd1; r_lo[0] = 16'h0100; r_hi[0] = 16'h0200;
    r_idx[1] = 4'd2; r_lo[1] = 16'h0200; r_hi[1] = 16'h0300;
    apply_map();
    a_valid = 3'b111;
    a_addr  = {16'h01F0, 16'h0250, 16'h0150};
    a_idin  = '0;
    a_rt    = 8'h5A;
    a_ri    = 1'b1;
    a_clr   = 1'b0;
    b_valid = 2'b11;
    b_addr  = '0;
    b_idin  = '0;
    b_map   = '0;
    b_rt    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    b_ri    = 1'b1;
    b_clr   = 1'b0;
    m_vld   = 1'b0;
    m_rr    = 0;
    m_cnt   = 0;

    #2 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_a_ready", 32'(a_ready), 32'd0);
      check_eq("rst_a_valid", 32'(a_vo), 32'd0);
      check_eq("rst_a_chan", 32'(a_chan), 32'd0);
      check_eq("rst_a_id", 32'(a_id), 32'd0);
      check_eq("rst_a_route", 32'(a_route), 32'd0);
      check_eq("rst_a_err", 32'(a_err), 32'd0);
      check_eq("rst_a_cnt", 32'(a_cnt), 32'd0);
      check_eq("rst_b_ready", 32'(b_ready), 32'd0);
      check_eq("rst_b_valid", 32'(b_vo), 32'd0);
    end
    rst = 1'b0;

    // Fairness: all requesting, sink always ready
    repeat (7) a_cycle();

    // Backpressure with the address map changing under a held result
    a_ri = 1'b0;
    a_cycle();
    r_idx[0] = 4'd7;
    apply_map();
    repeat (4) a_cycle();
    a_ri = 1'b1;
    repeat (4) a_cycle();
    r_idx[0] = 4'd1;
    apply_map();

    // Random valid subsets and sink stalls
    for (int i = 0; i < 24; i++) begin
      a_valid = 3'($urandom_range(0, 7));
      a_ri    = 1'($urandom_range(0, 1));
      a_cycle();
    end
    a_ri = 1'b1;
    a_valid = '0;
    repeat (2) a_cycle();

    // Single decode miss, then saturation and clear racing a 6th error
    a_addr[1*AW +: AW] = 16'h0050;
    a_valid = 3'b010;
    a_cycle();
    a_valid = '0;
    repeat (2) a_cycle();
    a_addr = {16'h0050, 16'h0050, 16'h0350};
    a_valid = 3'b111;
    repeat (5) a_cycle();
    check_eq("a_cnt_saturated", 32'(a_cnt), 32'd3);
    a_clr = 1'b1;
    a_cycle();
    a_clr = 1'b0;
    a_valid = '0;
    repeat (3) a_cycle();
    check_eq("a_sb_drained", 32'(sb.size()), 32'd0);

    // Source routing: in-range and out-of-range indices
    b_valid = '0;
    @(negedge clk);
    b_step(1, 4'd2, 8'hC2, 1'b0);
    b_step(0, 4'd5, 8'h00, 1'b1);
    b_step(1, 4'd3, 8'hD3, 1'b0);
    b_step(0, 4'd4, 8'h00, 1'b1);
    b_valid = '0;
    @(posedge clk);
    #1;
    check_eq("b_valid_clear", 32'(b_vo), 32'd0);
    check_eq("b_err_cnt", 32'(b_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
